// File: rtl/lfsr8_stepper_pkg.sv
// Shared definitions for the 8-bit button-stepped LFSR: width, feedback taps,
// action encoding and the single-step next-state function.
package lfsr8_stepper_pkg;

  localparam int LFSR_W = 8;

  // Taps at bits 4,3,2,0 realise x^8+x^4+x^3+x^2+1 (maximal length, period 255).
  localparam logic [LFSR_W-1:0] LFSR8_TAPS = 8'b0001_1101;

  typedef enum logic [1:0] {
    ACT_NONE = 2'b00,
    ACT_STEP = 2'b01,
    ACT_LOAD = 2'b10
  } act_e;

  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] v);
    return {^(v & LFSR8_TAPS), v[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw bouncy button, accepts a new level only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles, and flags its rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          prev_q;

  // Stability counter: any return to the accepted level restarts the count.
  always_comb begin
    cnt_d   = {CW{1'b0}};
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        level_d = level_q;
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      level_d = level_q;
      cnt_d   = {CW{1'b0}};
    end
  end

  // Synchroniser, counter, accepted level and its one-cycle-delayed copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/lfsr8_stepper.sv
// 8-bit Fibonacci LFSR advanced by a debounced step button and reloaded from
// switches by a debounced load button; drives two hex-digit decoders.
module lfsr8_stepper
  import lfsr8_stepper_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [7:0]  SEED            = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       btn_load,
  input  logic [7:0] seed_in,
  output logic [7:0] value,
  output logic [3:0] nib_lo,
  output logic [3:0] nib_hi,
  output logic [7:0] step_cnt,
  output logic       zero_fix,
  output logic       step_pulse
);

  logic              step_level;
  logic              step_rise;
  logic              load_level;
  logic              load_rise;
  logic              unused_levels;
  act_e              act;
  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;
  logic [7:0]        step_cnt_q;
  logic [7:0]        step_cnt_d;
  logic              zero_fix_q;
  logic              zero_fix_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_step),
    .level (step_level),
    .rise  (step_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_load),
    .level (load_level),
    .rise  (load_rise)
  );

  assign unused_levels = step_level ^ load_level;

  // Load has priority; a coincident step press is dropped entirely.
  always_comb begin
    act = ACT_NONE;
    if (load_rise) begin
      act = ACT_LOAD;
    end else if (step_rise) begin
      act = ACT_STEP;
    end else begin
      act = ACT_NONE;
    end
  end

  // Next LFSR state, step counter and zero-seed flag for the selected action.
  always_comb begin
    value_d    = value_q;
    step_cnt_d = step_cnt_q;
    zero_fix_d = zero_fix_q;
    case (act)
      ACT_LOAD: begin
        value_d    = (seed_in == 8'h00) ? SEED : seed_in;
        zero_fix_d = (seed_in == 8'h00);
        step_cnt_d = 8'h00;
      end
      ACT_STEP: begin
        value_d    = lfsr8_next(value_q);
        step_cnt_d = step_cnt_q + 8'h01;
      end
      default: begin
        value_d    = value_q;
        step_cnt_d = step_cnt_q;
        zero_fix_d = zero_fix_q;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q    <= SEED;
      step_cnt_q <= 8'h00;
      zero_fix_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      step_cnt_q <= step_cnt_d;
      zero_fix_q <= zero_fix_d;
    end
  end

  assign value      = value_q;
  assign nib_lo     = value_q[3:0];
  assign nib_hi     = value_q[7:4];
  assign step_cnt   = step_cnt_q;
  assign zero_fix   = zero_fix_q;
  assign step_pulse = (act == ACT_STEP);

endmodule

// File: tb/tb_lfsr8_stepper.sv
// Directed bench for lfsr8_stepper with a short debounce window.
module tb_lfsr8_stepper;

  logic       clk;
  logic       rst;
  logic       btn_step;
  logic       btn_load;
  logic [7:0] seed_in;
  logic [7:0] value;
  logic [3:0] nib_lo;
  logic [3:0] nib_hi;
  logic [7:0] step_cnt;
  logic       zero_fix;
  logic       step_pulse;

  int n_vec = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int pulse_cnt = 0;
  int last_pulse_edge = -1;

  lfsr8_stepper #(.DEBOUNCE_CYCLES(4), .SEED(8'h01)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_step   (btn_step),
    .btn_load   (btn_load),
    .seed_in    (seed_in),
    .value      (value),
    .nib_lo     (nib_lo),
    .nib_hi     (nib_hi),
    .step_cnt   (step_cnt),
    .zero_fix   (zero_fix),
    .step_pulse (step_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_edge = edge_cnt;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Press the selected buttons for hold cycles, then release and let them settle low.
  task automatic press(input logic s, input logic l, input int hold, output int n_edge);
    @(negedge clk);
    btn_step = s;
    btn_load = l;
    n_edge = edge_cnt + 1;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] v);
    return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
  endfunction

  initial begin
    int         n_edge;
    int         pc0;
    int         distinct;
    logic [7:0] model;
    logic [7:0] exp_seq [5];
    logic       seen [256];

    exp_seq[0] = 8'h80; exp_seq[1] = 8'h40; exp_seq[2] = 8'h20;
    exp_seq[3] = 8'h10; exp_seq[4] = 8'h88;

    rst = 1'b1; btn_step = 1'b0; btn_load = 1'b0; seed_in = 8'h00;
    do_reset();
    repeat (20) @(negedge clk);
    check_val("rst_value", value, 8'h01);
    check_val("rst_nib_hi", nib_hi, 4'h0);
    check_val("rst_nib_lo", nib_lo, 4'h1);
    check_val("rst_step_cnt", step_cnt, 8'h00);
    check_val("rst_zero_fix", zero_fix, 1'b0);
    check_val("rst_no_pulse", pulse_cnt, 0);

    // Glitches shorter than the debounce window.
    pc0 = pulse_cnt;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk); btn_step = 1'b1;
      repeat (3) @(negedge clk); btn_step = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_val("glitch_value", value, 8'h01);
    check_val("glitch_no_pulse", pulse_cnt - pc0, 0);

    // Five clean presses.
    for (int i = 0; i < 5; i++) begin
      pc0 = pulse_cnt;
      press(1'b1, 1'b0, 12, n_edge);
      check_val($sformatf("step%0d_value", i), value, exp_seq[i]);
      check_val($sformatf("step%0d_pulses", i), pulse_cnt - pc0, 1);
      check_val($sformatf("step%0d_latency", i), last_pulse_edge + 1 - n_edge, 6);
    end
    check_val("step5_cnt", step_cnt, 8'h05);
    check_val("step5_nib_hi", nib_hi, 4'h8);
    check_val("step5_nib_lo", nib_lo, 4'h8);

    // Loads.
    seed_in = 8'h5A;
    press(1'b0, 1'b1, 12, n_edge);
    check_val("load5a_value", value, 8'h5A);
    check_val("load5a_cnt", step_cnt, 8'h00);
    check_val("load5a_zero_fix", zero_fix, 1'b0);
    seed_in = 8'h00;
    press(1'b0, 1'b1, 12, n_edge);
    check_val("load00_value", value, 8'h01);
    check_val("load00_zero_fix", zero_fix, 1'b1);
    press(1'b1, 1'b0, 12, n_edge);
    check_val("zf_step_value", value, 8'h80);
    check_val("zf_step_keep", zero_fix, 1'b1);
    check_val("zf_step_cnt", step_cnt, 8'h01);

    // Step and load rising together: load wins.
    seed_in = 8'h33;
    pc0 = pulse_cnt;
    press(1'b1, 1'b1, 12, n_edge);
    check_val("both_value", value, 8'h33);
    check_val("both_cnt", step_cnt, 8'h00);
    check_val("both_no_pulse", pulse_cnt - pc0, 0);
    check_val("both_zero_fix", zero_fix, 1'b0);

    // Full period.
    do_reset();
    @(negedge clk);
    check_val("rst2_value", value, 8'h01);
    check_val("rst2_cnt", step_cnt, 8'h00);
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    model = 8'h01;
    distinct = 0;
    for (int i = 0; i < 255; i++) begin
      press(1'b1, 1'b0, 8, n_edge);
      model = ref_step(model);
      check_val($sformatf("period_%0d", i), value, model);
      if (!seen[value]) distinct++;
      seen[value] = 1'b1;
    end
    check_val("period_distinct", distinct, 255);
    check_val("period_zero_unseen", seen[0], 1'b0);
    check_val("period_return", value, 8'h01);
    check_val("period_cnt", step_cnt, 8'hFF);

    // Reset in the middle of a debounce count.
    pc0 = pulse_cnt;
    @(negedge clk); btn_step = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; btn_step = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    check_val("midrst_no_pulse", pulse_cnt - pc0, 0);
    check_val("midrst_cnt", step_cnt, 8'h00);
    check_val("midrst_value", value, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
